// File: rtl/hilo_div_seq.sv
// Sequential radix-2 restoring divider serving DIV/DIVU for the ALU HI/LO path.
// Fixed WIDTH+1 cycles from accept to validOut; requests arriving while busy are ignored.
module hilo_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state;
  logic             s_a, s_b;
  logic [WIDTH-1:0] abs_b, rem, quo;
  logic [CW-1:0]    count;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a_in, abs_b_in;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             take;

  assign neg_a    = sign & SrcA[WIDTH-1];
  assign neg_b    = sign & SrcB[WIDTH-1];
  assign abs_a_in = neg_a ? -SrcA : SrcA;
  assign abs_b_in = neg_b ? -SrcB : SrcB;

  // Remainder keeps a full W+1 bits so divisors with the MSB set still divide correctly.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign take   = (rem_sh >= {1'b0, abs_b});
  assign diff   = rem_sh[WIDTH-1:0] - abs_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s_a      <= 1'b0;
      s_b      <= 1'b0;
      abs_b    <= '0;
      rem      <= '0;
      quo      <= '0;
      count    <= '0;
      validOut <= 1'b0;
      busy     <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (validIn) begin
            s_a   <= neg_a;
            s_b   <= neg_b;
            quo   <= abs_a_in;
            abs_b <= abs_b_in;
            rem   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          rem   <= take ? diff : rem_sh[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], take};
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          Lo       <= (s_a ^ s_b) ? -quo : quo;
          Hi       <= s_a ? -rem : rem;
          validOut <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          validOut <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_seq.sv
// Scoreboard bench for hilo_div_seq: expected HI/LO pushed at request, popped at validOut.
module tb_hilo_div_seq;
  localparam int W = 32;
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         reset, validIn, sign;
  logic [W-1:0] SrcA, SrcB;
  logic         validOut, busy;
  logic [W-1:0] Hi, Lo;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  hilo_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .validIn(validIn), .sign(sign),
    .SrcA(SrcA), .SrcB(SrcB), .validOut(validOut), .Hi(Hi), .Lo(Lo), .busy(busy)
  );

  // Reference: {hi, lo} with truncating signed division and the divider's div-by-zero results.
  function automatic logic [2*W-1:0] model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      r = a;
      q = (sg && a[W-1]) ? W'(1) : ONES;
    end else if (sg) begin
      if (a == {1'b1, {(W-1){1'b0}}} && b == ONES) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic start_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    sign = sg; SrcA = a; SrcB = b; validIn = 1'b1;
    sb_q.push_back(model(sg, a, b));
    @(posedge clk); #1;
    validIn = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (validOut !== 1'b1 && n <= 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    logic [2*W-1:0] got;
    reset = 1'b1; validIn = 1'b0; sign = 1'b0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    got = {Hi, Lo};
    checks++;
    if (validOut !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl actual vo=%b busy=%b required vo=0 busy=0", validOut, busy);
    end
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_hilo actual=%h required=0", got);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic;
    int n;
    logic [2*W-1:0] exp;
    start_op(1'b0, 32'd100, 32'd7);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept actual=%b required=1", busy);
    end
    wait_result(n);
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL divu_latency actual=%0d required=33", n);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({Hi, Lo} !== exp) begin
      errors++;
      $display("FAIL divu_100_7 actual hi=%h lo=%h required hi=%h lo=%h", Hi, Lo, exp[2*W-1:W], exp[W-1:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (validOut !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width actual vo=%b busy=%b required vo=0 busy=0", validOut, busy);
    end
  endtask

  task automatic test_arith;
    logic           t_sg[0:10];
    logic [W-1:0]   t_a[0:10];
    logic [W-1:0]   t_b[0:10];
    int n;
    logic [2*W-1:0] exp;
    t_sg[0] = 1; t_a[0] = 32'hFFFFFFF9; t_b[0] = 32'd2;
    t_sg[1] = 1; t_a[1] = 32'd7;        t_b[1] = 32'hFFFFFFFE;
    t_sg[2] = 0; t_a[2] = 32'h12345678; t_b[2] = 32'd0;
    t_sg[3] = 1; t_a[3] = 32'hFFFFFFF0; t_b[3] = 32'd0;
    t_sg[4] = 1; t_a[4] = 32'h80000000; t_b[4] = 32'hFFFFFFFF;
    t_sg[5] = 0; t_a[5] = 32'hFFFFFFFF; t_b[5] = 32'hFFFFFFFE;
    t_sg[6] = 1; t_a[6] = 32'hFFFFFF9C; t_b[6] = 32'hFFFFFFF9;
    for (int i = 7; i <= 10; i++) begin
      t_sg[i] = 1'($urandom_range(1, 0));
      t_a[i]  = $urandom;
      t_b[i]  = $urandom_range(70000, 1);
      if (i[0]) t_b[i] = -t_b[i];
    end
    for (int i = 0; i <= 10; i++) begin
      start_op(t_sg[i], t_a[i], t_b[i]);
      wait_result(n);
      exp = sb_q.pop_front();
      checks++;
      if (n != 33 || {Hi, Lo} !== exp) begin
        errors++;
        $display("FAIL arith_%0d sg=%b a=%h b=%h actual lat=%0d hi=%h lo=%h required lat=33 hi=%h lo=%h",
                 i, t_sg[i], t_a[i], t_b[i], n, Hi, Lo, exp[2*W-1:W], exp[W-1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold_operands;
    int n;
    logic [2*W-1:0] exp;
    sign = 1'b0; SrcA = 32'd1000; SrcB = 32'd10; validIn = 1'b1;
    sb_q.push_back(model(1'b0, 32'd1000, 32'd10));
    @(posedge clk); #1;
    n = 0;
    while (validOut !== 1'b1 && n <= 40) begin
      SrcA = $urandom; SrcB = $urandom; sign = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      n++;
    end
    exp = sb_q.pop_front();
    checks++;
    if (n != 33 || {Hi, Lo} !== exp) begin
      errors++;
      $display("FAIL hold_operands actual lat=%0d hi=%h lo=%h required lat=33 hi=%h lo=%h",
               n, Hi, Lo, exp[2*W-1:W], exp[W-1:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || validOut !== 1'b0) begin
      errors++;
      $display("FAIL valid_in_done actual busy=%b vo=%b required busy=0 vo=0", busy, validOut);
    end
    validIn = 1'b0; sign = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n, pulses;
    logic [2*W-1:0] exp;
    start_op(1'b0, 32'd50, 32'd5);
    void'(sb_q.pop_back());
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (validOut !== 1'b0 || busy !== 1'b0 || Hi !== '0 || Lo !== '0) begin
      errors++;
      $display("FAIL reset_mid actual vo=%b busy=%b hi=%h lo=%h required all 0", validOut, busy, Hi, Lo);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (validOut === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL no_pulse_after_abort actual=%0d required=0", pulses);
    end
    start_op(1'b0, 32'd9, 32'd3);
    wait_result(n);
    exp = sb_q.pop_front();
    checks++;
    if (n != 33 || {Hi, Lo} !== exp) begin
      errors++;
      $display("FAIL after_reset_9_3 actual lat=%0d hi=%h lo=%h required lat=33 hi=%h lo=%h",
               n, Hi, Lo, exp[2*W-1:W], exp[W-1:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n, unstable;
    logic [2*W-1:0] exp, held;
    start_op(1'b0, 32'hFFFFFFFF, 32'd1);
    wait_result(n);
    exp = sb_q.pop_front();
    checks++;
    if (n != 33 || {Hi, Lo} !== exp) begin
      errors++;
      $display("FAIL b2b_first actual lat=%0d hi=%h lo=%h required lat=33 hi=%h lo=%h",
               n, Hi, Lo, exp[2*W-1:W], exp[W-1:0]);
    end
    held = exp;
    @(posedge clk); #1;
    start_op(1'b0, 32'd1, 32'hFFFFFFFF);
    n = 0; unstable = 0;
    while (validOut !== 1'b1 && n <= 40) begin
      if ({Hi, Lo} !== held) unstable++;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL hilo_stable actual_changes=%0d required=0", unstable);
    end
    exp = sb_q.pop_front();
    checks++;
    if (n != 33 || {Hi, Lo} !== exp) begin
      errors++;
      $display("FAIL b2b_second actual lat=%0d hi=%h lo=%h required lat=33 hi=%h lo=%h",
               n, Hi, Lo, exp[2*W-1:W], exp[W-1:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_arith();
    test_hold_operands();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
